// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg
// Shared definitions for the latch_bank block: the per-channel capture mode
// encoding and the width helper for the enable glitch-filter counter.
package latch_bank_pkg;

    typedef enum logic {
        LATCH_LEVEL = 1'b0,
        LATCH_EDGE  = 1'b1
    } latch_mode_e;

    // The counter only ever holds 0..STABLE_CYCLES-1, but sizing it for
    // STABLE_CYCLES+1 values keeps it at least one bit wide for STABLE_CYCLES=1.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/latch_bank_en_filter.sv
// en_filter
// Glitch filter for one raw enable. The filtered enable toggles only after
// the raw enable has disagreed with it for STABLE_CYCLES consecutive samples.
// Any sample that agrees restarts the count.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   en      in   raw enable, sampled every edge
//   en_eff  out  filtered enable (registered)
//   en_nxt  out  value en_eff will load at the current edge (combinational)
module en_filter
    import latch_bank_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic en_eff,
    output logic en_nxt
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    // Comparing against the last count value, rather than incrementing and
    // comparing to STABLE_CYCLES, means the counter never has to hold STABLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             en_eff_q;
    logic             en_eff_d;

    always_comb begin
        en_eff_d = en_eff_q;
        cnt_d    = '0;
        if (en != en_eff_q) begin
            if (cnt_q == CNT_LAST) begin
                en_eff_d = ~en_eff_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            en_eff_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            en_eff_q <= en_eff_d;
        end
    end

    assign en_eff = en_eff_q;
    assign en_nxt = en_eff_d;

endmodule

// File: rtl/latch_bank.sv
// latch_bank
// Bank of CHANNELS independent, fully clocked WIDTH-bit latches. Each channel
// has its own enable glitch filter and a capture mode: LEVEL follows d on
// every edge the filtered enable is high, EDGE captures once per filtered
// rising edge. A one-cycle changed pulse accompanies every capture that
// altered the stored value.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   mode     in   [CHANNELS]       per channel: 0 = LEVEL, 1 = EDGE
//   en       in   [CHANNELS]       raw per-channel enable
//   d        in   [CHANNELS*WIDTH] data, channel i at d[i*WIDTH +: WIDTH]
//   q        out  [CHANNELS*WIDTH] latched data, same packing as d
//   en_eff   out  [CHANNELS]       filtered enable
//   changed  out  [CHANNELS]       pulse: q changed value at the previous edge
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       en_eff,
    output logic [CHANNELS-1:0]       changed
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             en_nxt;
        logic             capture;
        logic [WIDTH-1:0] d_ch;
        logic [WIDTH-1:0] q_q;
        logic [WIDTH-1:0] q_d;
        logic             changed_q;
        logic             changed_d;

        en_filter #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_filter (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en[i]),
            .en_eff(en_eff[i]),
            .en_nxt(en_nxt)
        );

        assign d_ch = d[i*WIDTH +: WIDTH];

        // Mode is evaluated against the enable being loaded at this same
        // edge, so a mode flip and an enable change on one edge combine cleanly.
        always_comb begin
            capture   = 1'b0;
            q_d       = q_q;
            changed_d = 1'b0;
            if (latch_mode_e'(mode[i]) == LATCH_EDGE) begin
                capture = en_nxt & ~en_eff[i];
            end else begin
                capture = en_nxt;
            end
            if (capture) begin
                q_d       = d_ch;
                changed_d = (d_ch != q_q);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_q       <= '0;
                changed_q <= 1'b0;
            end else begin
                q_q       <= q_d;
                changed_q <= changed_d;
            end
        end

        assign q[i*WIDTH +: WIDTH] = q_q;
        assign changed[i]          = changed_q;
    end

endmodule
